// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32 core.
// Latches the decoded control bundle and operands once per cycle, detects
// load-use hazards (stalling PC and IF/ID and injecting a bubble into EX) and
// honours a global freeze from the memory system.
// Optional build macro: ID_EX_STALL_CNT_EN adds a 32-bit stall counter output.
module id_ex_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               freeze_i,
  input  logic               RegWrite_i,
  input  logic               MemToReg_i,
  input  logic               MemRead_i,
  input  logic               MemWrite_i,
  input  logic [1:0]         ALUOp_i,
  input  logic               ALUSrc_i,
  input  logic [XLEN-1:0]    RS1data_i,
  input  logic [XLEN-1:0]    RS2data_i,
  input  logic [XLEN-1:0]    imm_i,
  input  logic [9:0]         funct_i,
  input  logic [RADDR_W-1:0] RS1addr_i,
  input  logic [RADDR_W-1:0] RS2addr_i,
  input  logic [RADDR_W-1:0] RDaddr_i,
  output logic               RegWrite_o,
  output logic               MemToReg_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic [1:0]         ALUOp_o,
  output logic               ALUSrc_o,
  output logic [XLEN-1:0]    RS1data_o,
  output logic [XLEN-1:0]    RS2data_o,
  output logic [XLEN-1:0]    imm_o,
  output logic [9:0]         funct_o,
  output logic [RADDR_W-1:0] RS1addr_o,
  output logic [RADDR_W-1:0] RS2addr_o,
  output logic [RADDR_W-1:0] RDaddr_o,
`ifdef ID_EX_STALL_CNT_EN
  output logic [31:0]        stall_cnt_o,
`endif
  output logic               stall_o,
  output logic               PCWrite_o,
  output logic               IFIDWrite_o
);

  // Control bundle from the decoder; a bubble is this bundle all zero.
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       alu_src;
  } ctrl_t;

  ctrl_t              ctrl_d, ctrl_q;
  logic [XLEN-1:0]    rs1_data_q, rs2_data_q, imm_q;
  logic [9:0]         funct_q;
  logic [RADDR_W-1:0] rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic               stall;

  // Load-use hazard: the instruction in EX is a load whose rd (non-x0) is a
  // source of the instruction in ID. rs2 is compared even for I-type users.
  always_comb begin
    stall = ctrl_q.mem_read && (rd_addr_q != '0) &&
            ((rd_addr_q == RS1addr_i) || (rd_addr_q == RS2addr_i));
  end

  // Select the next control bundle: a bubble while stalling, else the decode.
  always_comb begin
    // NOTE: assign a default first so every path drives ctrl_d and no latch is inferred.
    ctrl_d = '{reg_write:  RegWrite_i,
               mem_to_reg: MemToReg_i,
               mem_read:   MemRead_i,
               mem_write:  MemWrite_i,
               alu_op:     ALUOp_i,
               alu_src:    ALUSrc_i};
    if (stall) begin
      ctrl_d = '0;
    end
  end

  // Pipeline register: freeze holds everything, otherwise capture each cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: these are plain flops, not a memory array, so resetting every field is cheap and keeps bubbles clean.
    if (!rst_i) begin
      ctrl_q     <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      funct_q    <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
    end else if (!freeze_i) begin
      // NOTE: non-blocking assignments so all fields update together from pre-edge values.
      ctrl_q     <= ctrl_d;
      rs1_data_q <= RS1data_i;
      rs2_data_q <= RS2data_i;
      imm_q      <= imm_i;
      funct_q    <= funct_i;
      rs1_addr_q <= RS1addr_i;
      rs2_addr_q <= RS2addr_i;
      rd_addr_q  <= RDaddr_i;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;

  // Stall counter next value; wraps naturally at 32 bits.
  always_comb begin
    stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Count edges that actually inject a bubble (stalled and not frozen).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall && !freeze_i) begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  assign RegWrite_o  = ctrl_q.reg_write;
  assign MemToReg_o  = ctrl_q.mem_to_reg;
  assign MemRead_o   = ctrl_q.mem_read;
  assign MemWrite_o  = ctrl_q.mem_write;
  assign ALUOp_o     = ctrl_q.alu_op;
  assign ALUSrc_o    = ctrl_q.alu_src;
  assign RS1data_o   = rs1_data_q;
  assign RS2data_o   = rs2_data_q;
  assign imm_o       = imm_q;
  assign funct_o     = funct_q;
  assign RS1addr_o   = rs1_addr_q;
  assign RS2addr_o   = rs2_addr_q;
  assign RDaddr_o    = rd_addr_q;
  assign stall_o     = stall;
  assign PCWrite_o   = ~stall & ~freeze_i;
  assign IFIDWrite_o = ~stall & ~freeze_i;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, pass-through, load-use bubble,
// x0 exemption, freeze during stall, reset mid-stall and (optionally) the
// stall counter including wrap-around.
module tb_id_ex_stage;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               freeze_i;
  logic               RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, ALUSrc_i;
  logic [1:0]         ALUOp_i;
  logic [XLEN-1:0]    RS1data_i, RS2data_i, imm_i;
  logic [9:0]         funct_i;
  logic [RADDR_W-1:0] RS1addr_i, RS2addr_i, RDaddr_i;
  logic               RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, ALUSrc_o;
  logic [1:0]         ALUOp_o;
  logic [XLEN-1:0]    RS1data_o, RS2data_o, imm_o;
  logic [9:0]         funct_o;
  logic [RADDR_W-1:0] RS1addr_o, RS2addr_o, RDaddr_o;
  logic               stall_o, PCWrite_o, IFIDWrite_o;
`ifdef ID_EX_STALL_CNT_EN
  logic [31:0]        stall_cnt_o;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  id_ex_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .freeze_i(freeze_i),
    .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .imm_i(imm_i),
    .funct_i(funct_i), .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i),
    .RDaddr_i(RDaddr_i),
    .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o),
    .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .imm_o(imm_o),
    .funct_o(funct_o), .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o),
    .RDaddr_o(RDaddr_o),
`ifdef ID_EX_STALL_CNT_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .stall_o(stall_o), .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one ID-stage instruction; all other inputs go to zero.
  task automatic drive(input logic rw, input logic mtr, input logic mr, input logic mw,
                       input logic [1:0] aop, input logic asrc,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im,
                       input logic [9:0] fn, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] rd);
    RegWrite_i = rw;  MemToReg_i = mtr; MemRead_i = mr; MemWrite_i = mw;
    ALUOp_i    = aop; ALUSrc_i   = asrc;
    RS1data_i  = d1;  RS2data_i  = d2;  imm_i = im;  funct_i = fn;
    RS1addr_i  = a1;  RS2addr_i  = a2;  RDaddr_i = rd;
  endtask

  initial begin
    rst_i    = 1'b1;
    freeze_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0, '0, '0, '0, '0, '0);
    #1 rst_i = 1'b0;

    // Reset with busy inputs: outputs stay clear, PC/IF-ID enabled.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678,
          32'hFFFF_FFF0, 10'h2A5, 5'd1, 5'd2, 5'd7);
    tick(); tick();
    check("rst_regwrite", {31'd0, RegWrite_o}, 32'd0);
    check("rst_memread",  {31'd0, MemRead_o}, 32'd0);
    check("rst_rs1data",  RS1data_o, 32'd0);
    check("rst_rdaddr",   {27'd0, RDaddr_o}, 32'd0);
    check("rst_stall",    {31'd0, stall_o}, 32'd0);
    check("rst_pcwrite",  {31'd0, PCWrite_o}, 32'd1);
    check("rst_ifidwrite",{31'd0, IFIDWrite_o}, 32'd1);

    // Release reset between edges; next edge captures the inputs.
    rst_i = 1'b1;
    tick();
    check("rel_memread",  {31'd0, MemRead_o}, 32'd1);
    check("rel_memwrite", {31'd0, MemWrite_o}, 32'd1);
    check("rel_aluop",    {30'd0, ALUOp_o}, 32'd3);
    check("rel_rs1data",  RS1data_o, 32'hDEAD_BEEF);
    check("rel_rs2data",  RS2data_o, 32'h1234_5678);
    check("rel_imm",      imm_o, 32'hFFFF_FFF0);
    check("rel_funct",    {22'd0, funct_o}, 32'h2A5);
    check("rel_rdaddr",   {27'd0, RDaddr_o}, 32'd7);

    // Pass-through of an R-type add.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0005, '0, '0, '0, 5'd0, 5'd0, 5'd3);
    tick();
    check("pt_regwrite",  {31'd0, RegWrite_o}, 32'd1);
    check("pt_aluop",     {30'd0, ALUOp_o}, 32'd2);
    check("pt_rs1data",   RS1data_o, 32'h5);
    check("pt_rdaddr",    {27'd0, RDaddr_o}, 32'd3);
    check("pt_memread",   {31'd0, MemRead_o}, 32'd0);
    check("pt_stall",     {31'd0, stall_o}, 32'd0);

    // Load-use: lw x5 then a consumer of x5 on rs1.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, '0, '0, 32'd8, 10'h002, 5'd0, 5'd0, 5'd5);
    tick();
    check("lu_lw_memread", {31'd0, MemRead_o}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h11, 32'h22, '0, 10'h000, 5'd5, 5'd1, 5'd6);
    #1;
    check("lu_stall",     {31'd0, stall_o}, 32'd1);
    check("lu_pcwrite",   {31'd0, PCWrite_o}, 32'd0);
    check("lu_ifidwrite", {31'd0, IFIDWrite_o}, 32'd0);
    tick();
    check("lu_bub_regwrite", {31'd0, RegWrite_o}, 32'd0);
    check("lu_bub_aluop",    {30'd0, ALUOp_o}, 32'd0);
    check("lu_bub_memread",  {31'd0, MemRead_o}, 32'd0);
    check("lu_bub_rdaddr",   {27'd0, RDaddr_o}, 32'd6);
    check("lu_bub_rs1data",  RS1data_o, 32'h11);
    check("lu_bub_stall",    {31'd0, stall_o}, 32'd0);
`ifdef ID_EX_STALL_CNT_EN
    check("lu_cnt",          stall_cnt_o, 32'd1);
`endif
    // IF/ID held the consumer; it now enters EX normally.
    tick();
    check("lu_replay_regwrite", {31'd0, RegWrite_o}, 32'd1);
    check("lu_replay_aluop",    {30'd0, ALUOp_o}, 32'd2);

    // x0 exemption: lw x0 followed by a reader of x0 on rs2.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, '0, '0, '0, '0, 5'd3, 5'd3, 5'd0);
    tick();
    check("x0_memread", {31'd0, MemRead_o}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, '0, '0, '0, '0, 5'd1, 5'd0, 5'd4);
    #1;
    check("x0_stall",   {31'd0, stall_o}, 32'd0);
    check("x0_pcwrite", {31'd0, PCWrite_o}, 32'd1);
    tick();
    check("x0_regwrite", {31'd0, RegWrite_o}, 32'd1);
    check("x0_rdaddr",   {27'd0, RDaddr_o}, 32'd4);

    // Freeze during a stall: everything holds for three edges.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, '0, '0, '0, '0, 5'd0, 5'd0, 5'd9);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'hAA, '0, '0, '0, 5'd2, 5'd9, 5'd10);
    freeze_i = 1'b1;
    #1;
    check("fz_stall",   {31'd0, stall_o}, 32'd1);
    check("fz_pcwrite", {31'd0, PCWrite_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fz_hold_memread", {31'd0, MemRead_o}, 32'd1);
      check("fz_hold_rdaddr",  {27'd0, RDaddr_o}, 32'd9);
      check("fz_hold_stall",   {31'd0, stall_o}, 32'd1);
      check("fz_hold_ifid",    {31'd0, IFIDWrite_o}, 32'd0);
`ifdef ID_EX_STALL_CNT_EN
      check("fz_hold_cnt",     stall_cnt_o, 32'd1);
`endif
    end
    freeze_i = 1'b0;
    #1;
    check("fz_rel_stall", {31'd0, stall_o}, 32'd1);
    tick();
    check("fz_bub_regwrite", {31'd0, RegWrite_o}, 32'd0);
    check("fz_bub_rdaddr",   {27'd0, RDaddr_o}, 32'd10);
    check("fz_bub_rs1data",  RS1data_o, 32'hAA);
    check("fz_bub_stall",    {31'd0, stall_o}, 32'd0);
`ifdef ID_EX_STALL_CNT_EN
    check("fz_bub_cnt",      stall_cnt_o, 32'd2);
`endif

    // Reset asserted mid-stall clears outputs immediately.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, '0, '0, '0, '0, 5'd0, 5'd0, 5'd12);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, '0, '0, '0, '0, 5'd12, 5'd0, 5'd13);
    #1;
    check("mr_pre_stall", {31'd0, stall_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    check("mr_memread", {31'd0, MemRead_o}, 32'd0);
    check("mr_rdaddr",  {27'd0, RDaddr_o}, 32'd0);
    check("mr_stall",   {31'd0, stall_o}, 32'd0);
    check("mr_pcwrite", {31'd0, PCWrite_o}, 32'd1);
`ifdef ID_EX_STALL_CNT_EN
    check("mr_cnt",     stall_cnt_o, 32'd0);
`endif
    rst_i = 1'b1;

`ifdef ID_EX_STALL_CNT_EN
    // Counter wrap: preload all-ones, then one load-use stall.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, '0, '0, '0, '0, 5'd0, 5'd0, 5'd8);
    tick();
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    #1;
    check("wrap_pre_cnt", stall_cnt_o, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, '0, '0, '0, '0, 5'd8, 5'd0, 5'd14);
    tick();
    check("wrap_cnt", stall_cnt_o, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
